hood_display_driver: RTL and testbench

- Reader side of the range-hood mode state machine: consumes its registered `state` code and the active countdown's `time_left`.
- Renders mode, countdown and wall-clock time on the board's 8-digit multiplexed 7-segment display.
- Contains the digit-scan divider, blink divider, per-frame snapshot and a sequential binary-to-BCD converter.
- Sits between the mode state machine / timers and the display pins.

---
 rtl/hood_display_driver.sv | 141 ++++++++++++++
 tb/tb_hood_display_driver.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/hood_display_driver.sv
// hood_display_driver: scans mode, countdown and wall-clock onto an 8-digit 7-segment display.
// A frame snapshot taken at each 7->0 wrap keeps every rendered frame coherent.
module hood_display_driver #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int SCAN_HZ  = 1000,
  parameter int BLINK_HZ = 2,
  parameter int BLINK_TH = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] state,
  input  logic [7:0] time_left,
  input  logic [4:0] clock_hh,
  input  logic [5:0] clock_mm,
  input  logic [5:0] clock_ss,
  output logic [7:0] seg,
  output logic [7:0] an
);
  localparam int SCAN_DIV  = CLK_FREQ / (SCAN_HZ * 8);
  localparam int BLINK_DIV = CLK_FREQ / (2 * BLINK_HZ);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);

  logic [SW-1:0]   scan_cnt;
  logic [BW-1:0]   blink_cnt;
  logic            blink_phase, tick, btick, wrap, blink_off;
  logic [2:0]      idx, idx_n, st_s;
  logic [7:0]      tl_s, hh_p, mm_p, ss_p;
  logic [4:0]      hh_s;
  logic [5:0]      mm_s, ss_s;
  logic [19:0]     dd;
  logic [3:0]      bcnt, h_d, t_d, o_d;
  logic [7:0][7:0] g;

  function automatic logic [7:0] dig(input logic [3:0] d);
    case (d)
      4'd0: dig = 8'h3f;
      4'd1: dig = 8'h06;
      4'd2: dig = 8'h5b;
      4'd3: dig = 8'h4f;
      4'd4: dig = 8'h66;
      4'd5: dig = 8'h6d;
      4'd6: dig = 8'h7d;
      4'd7: dig = 8'h07;
      4'd8: dig = 8'h7f;
      4'd9: dig = 8'h6f;
      default: dig = 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] split(input logic [5:0] v);
    split = v >= 6'd50 ? {4'd5, 4'(v - 6'd50)} :
            v >= 6'd40 ? {4'd4, 4'(v - 6'd40)} :
            v >= 6'd30 ? {4'd3, 4'(v - 6'd30)} :
            v >= 6'd20 ? {4'd2, 4'(v - 6'd20)} :
            v >= 6'd10 ? {4'd1, 4'(v - 6'd10)} : {4'd0, v[3:0]};
  endfunction

  function automatic logic [15:0] pair(input logic [7:0] p, input logic bad, input logic dp);
    pair = bad ? {8'h79, 8'h79 | {dp, 7'd0}} : {dig(p[7:4]), dig(p[3:0]) | {dp, 7'd0}};
  endfunction

  // One double-dabble step: add-3 correction on each BCD nibble, then shift.
  function automatic logic [19:0] dab(input logic [19:0] v);
    dab = {v[19:16] >= 4'd5 ? v[19:16] + 4'd3 : v[19:16],
           v[15:12] >= 4'd5 ? v[15:12] + 4'd3 : v[15:12],
           v[11:8]  >= 4'd5 ? v[11:8]  + 4'd3 : v[11:8],
           v[7:0]} << 1;
  endfunction

  always_comb begin
    tick      = scan_cnt == SW'(SCAN_DIV - 1);
    btick     = blink_cnt == BW'(BLINK_DIV - 1);
    idx_n     = an == 8'd0 ? 3'd0 : idx + 3'd1;
    wrap      = tick && an != 8'd0 && idx == 3'd7;
    hh_p      = split({1'b0, hh_s});
    mm_p      = split(mm_s);
    ss_p      = split(ss_s);
    blink_off = tl_s != 8'd0 && tl_s <= 8'(BLINK_TH) && !blink_phase;
    g         = '0;
    g[7]      = st_s == 3'd7 ? 8'h79 : dig({1'b0, st_s});
    case (st_s)
      3'd1: g[3:0] = {4{8'h40}};
      3'd2: g[0] = dig(4'd1);
      3'd3: g[0] = dig(4'd2);
      3'd4, 3'd5: begin
        g[2] = h_d == 4'd0 || blink_off ? 8'h00 : dig(h_d);
        g[1] = (h_d == 4'd0 && t_d == 4'd0) || blink_off ? 8'h00 : dig(t_d);
        g[0] = blink_off ? 8'h00 : dig(o_d);
      end
      3'd6: g[5:0] = {pair(hh_p, hh_s > 5'd23, 1'b1), pair(mm_p, mm_s > 6'd59, 1'b1),
                      pair(ss_p, ss_s > 6'd59, 1'b0)};
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt    <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
      idx         <= '0;
      seg         <= '0;
      an          <= '0;
      st_s        <= '0;
      tl_s        <= '0;
      hh_s        <= '0;
      mm_s        <= '0;
      ss_s        <= '0;
      dd          <= '0;
      bcnt        <= '0;
      h_d         <= '0;
      t_d         <= '0;
      o_d         <= '0;
    end else begin
      scan_cnt  <= tick ? '0 : scan_cnt + SW'(1);
      blink_cnt <= btick ? '0 : blink_cnt + BW'(1);
      if (btick) blink_phase <= !blink_phase;
      if (tick) begin
        idx <= idx_n;
        an  <= 8'd1 << idx_n;
        seg <= g[idx_n];
      end
      if (wrap) begin
        st_s <= state;
        tl_s <= time_left;
        hh_s <= clock_hh;
        mm_s <= clock_mm;
        ss_s <= clock_ss;
        dd   <= {12'd0, time_left};
        bcnt <= 4'd1;
      end else if (bcnt == 4'd9) begin
        {h_d, t_d, o_d} <= dd[19:8];
        bcnt            <= '0;
      end else if (bcnt != 4'd0) begin
        dd   <= dab(dd);
        bcnt <= bcnt + 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_hood_display_driver.sv
// tb_hood_display_driver: randomized and directed frames checked against a per-frame display model.
module tb_hood_display_driver;
  localparam logic [7:0] LUT [10] = '{8'h3f, 8'h06, 8'h5b, 8'h4f, 8'h66, 8'h6d, 8'h7d, 8'h07, 8'h7f, 8'h6f};

  typedef struct packed {
    logic [2:0] st;
    logic [7:0] tl;
    logic [4:0] hh;
    logic [5:0] mm;
    logic [5:0] ss;
  } snap_t;

  logic       clk = 0, reset = 1;
  logic [2:0] state = 0;
  logic [7:0] time_left = 0;
  logic [4:0] clock_hh = 0;
  logic [5:0] clock_mm = 0, clock_ss = 0;
  logic [7:0] seg, an;
  int         checks = 0, errors = 0, cyc = 0, k = 0, d, f;
  bit         ph;
  snap_t      sn;
  snap_t      rec [4096];

  hood_display_driver #(.CLK_FREQ(800), .SCAN_HZ(10), .BLINK_HZ(4), .BLINK_TH(5)) dut (
    .clk(clk), .reset(reset), .state(state), .time_left(time_left),
    .clock_hh(clock_hh), .clock_mm(clock_mm), .clock_ss(clock_ss), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h, expected %02h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_glyph(input snap_t s, input bit p, input int dg);
    int tl, v, lim;
    logic [7:0] dp;
    tl = int'(s.tl);
    if (dg == 7) return s.st == 3'd7 ? 8'h79 : LUT[s.st];
    case (s.st)
      3'd1: return dg <= 3 ? 8'h40 : 8'h00;
      3'd2: return dg == 0 ? LUT[1] : 8'h00;
      3'd3: return dg == 0 ? LUT[2] : 8'h00;
      3'd4, 3'd5: begin
        if (dg > 2 || (tl >= 1 && tl <= 5 && !p)) return 8'h00;
        if (dg == 2) return tl >= 100 ? LUT[tl / 100] : 8'h00;
        if (dg == 1) return tl >= 10 ? LUT[(tl / 10) % 10] : 8'h00;
        return LUT[tl % 10];
      end
      3'd6: begin
        if (dg > 5) return 8'h00;
        v   = dg >= 4 ? int'(s.hh) : dg >= 2 ? int'(s.mm) : int'(s.ss);
        lim = dg >= 4 ? 23 : 59;
        dp  = (dg == 4 || dg == 2) ? 8'h80 : 8'h00;
        if (v > lim) return 8'h79 | dp;
        return ((dg % 2) == 1 ? LUT[v / 10] : LUT[v % 10]) | dp;
      end
      default: return 8'h00;
    endcase
  endfunction

  // Digit d shown at scan tick k belongs to the frame snapshotted at the wrap
  // that preceded it; digit 0 closes the frame one wrap later.
  always @(posedge clk) begin
    if (reset) begin
      cyc = 0;
      k   = 0;
    end else begin
      cyc++;
      if (cyc == 9) begin
        #1;
        chk("an_before_first_tick", an, 8'h00);
      end else if (cyc % 10 == 0 && k < 4095) begin
        k++;
        if (k >= 9 && (k - 1) % 8 == 0) rec[k] = '{state, time_left, clock_hh, clock_mm, clock_ss};
        d  = (k - 1) % 8;
        f  = d == 0 ? k - 8 : k - d;
        sn = f >= 9 ? rec[f] : '0;
        ph = ((cyc - 1) / 100) % 2 == 0;
        #1;
        chk($sformatf("an_tick%0d", k), an, 8'(1 << d));
        chk($sformatf("seg_d%0d_st%0d_tl%0d", d, sn.st, sn.tl), seg, exp_glyph(sn, ph, d));
      end
    end
  end

  task automatic set_in(input logic [2:0] st, input logic [7:0] tl, input logic [4:0] h,
                        input logic [5:0] m, input logic [5:0] s);
    @(negedge clk);
    state     = st;
    time_left = tl;
    clock_hh  = h;
    clock_mm  = m;
    clock_ss  = s;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    run(3);
    reset = 0;
    run(125);
    @(posedge clk);
    #2 reset = 1;
    #1;
    chk("an_async_reset", an, 8'h00);
    chk("seg_async_reset", seg, 8'h00);
    run(2);
    reset = 0;
    set_in(3'd4, 8'd125, 5'd0, 6'd0, 6'd0);
    run(240);
    set_in(3'd5, 8'd7, 5'd0, 6'd0, 6'd0);
    run(240);
    set_in(3'd5, 8'd3, 5'd0, 6'd0, 6'd0);
    run(500);
    set_in(3'd5, 8'd0, 5'd0, 6'd0, 6'd0);
    run(240);
    set_in(3'd6, 8'd0, 5'd23, 6'd59, 6'd7);
    run(240);
    set_in(3'd6, 8'd0, 5'd24, 6'd60, 6'd59);
    run(240);
    set_in(3'd4, 8'd40, 5'd0, 6'd0, 6'd0);
    run(200 + $urandom_range(3, 70));
    time_left = 8'd90;
    run(240);
    set_in(3'd7, 8'd0, 5'd0, 6'd0, 6'd0);
    run(240);
    set_in(3'd1, 8'd0, 5'd0, 6'd0, 6'd0);
    run(240);
    for (int i = 0; i < 20; i++) begin
      set_in(3'($urandom_range(7)),
             $urandom_range(1) == 1 ? 8'($urandom_range(12)) : 8'($urandom_range(255)),
             5'($urandom_range(31)), 6'($urandom_range(63)), 6'($urandom_range(63)));
      run($urandom_range(200, 30));
    end
    run(20);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
